mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
- Memory-stage controller that sits directly downstream of the ALU.
- Takes the ALU result (y) as the effective address, plus the store data and 8-bit op for LW/LH/LHU/LB/LBU/SW/SH/SB.
- Checks alignment, drives a split-transaction data-bus handshake (addr_ok / data_ok), and returns sign- or zero-extended load data.
- Stalls the pipeline until the access completes, using the same stall style as the ALU's mut_div_stall.

Parameters:
- ADDR_W, 32, data-bus address width.
- DATA_W, 32, data-bus data width (fixed at 32; lane logic assumes 4 bytes).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- valid_i  in  1  op_i/addr_i/wdata_i hold a live instruction.
- op_i  in  8  EXE_*_OP code from defines.vh.
- addr_i  in  32  effective address (ALU y).
- wdata_i  in  32  store source (rt value).
- flush_i  in  1  kill the current instruction (exception or branch flush).
- hold_i  in  1  a downstream or other-unit stall is holding this stage.
- stall_o  out  1  request to freeze the pipeline.
- rdata_o  out  32  extended load result; valid while done_o=1.
- done_o  out  1  access completed this cycle.
- adel_o  out  1  load address error.
- ades_o  out  1  store address error.
- badvaddr_o  out  32  faulting address.
- data_req  out  1  bus request.
- data_wr  out  1  1 = store.
- data_size  out  2  0 = byte, 1 = half, 2 = word.
- data_addr  out  32  bus address.
- data_wdata  out  32  lane-replicated store data.
- data_addr_ok  in  1  request accepted this cycle.
- data_data_ok  in  1  read data valid / write done.
- data_rdata  in  32  raw read word.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all internal registers cleared; every output 0.
- mem_op = valid_i & op_i is one of the 8 memory ops.
- Alignment errors (combinational, any state where op_i is examined):
  - LW/SW with addr_i[1:0]!=0.
  - LH/LHU/SH with addr_i[0]=1.
  - On error: adel_o or ades_o =1, badvaddr_o=addr_i, no data_req, stall_o=0, FSM stays in IDLE.
- flush_i blocks any new issue in all states.
- Store lanes: SB data_wdata={4{wdata_i[7:0]}}; SH {2{wdata_i[15:0]}}; SW wdata_i. data_addr carries the full byte address.
- IDLE:
  - issue = mem_op & ~error & ~flush_i.
  - data_req = issue; bus fields are taken directly from the inputs; stall_o = issue.
  - addr_ok=1 -> WAIT; otherwise -> REQ.
  - On issue, latch op, addr[1:0], size and store data.
- REQ:
  - data_req=1 with latched fields, held stable until addr_ok; stall_o=1.
  - addr_ok -> WAIT.
  - flush_i without addr_ok -> IDLE; the request is withdrawn and no transaction occurs.
- WAIT:
  - data_req=0; stall_o=1.
  - data_ok -> DONE; capture the extended load data.
  - flush_i -> DRAIN.
  - flush_i and data_ok in the same cycle -> IDLE; the data is discarded.
- DONE:
  - done_o=1; stall_o=0; rdata_o valid.
  - hold_i=1 -> stay in DONE with rdata_o stable, and do not reissue.
  - hold_i=0 or flush_i -> IDLE.
- DRAIN:
  - Outstanding transaction is being discarded; data_req=0; done_o=0.
  - stall_o = mem_op.
  - data_ok -> IDLE; the data is discarded.
- Load extraction by latched addr[1:0]:
  - LB/LBU: byte lane = addr*8, sign- or zero-extended.
  - LH/LHU: half lane = addr[1]*16.
  - LW: full word.
- Stores: rdata_o=0; done_o still pulses.
- Minimum latency: issue with addr_ok in cycle 0, data_ok in cycle 1, done in cycle 2. stall_o is high in cycles 0-1.
- At most one outstanding transaction at any time.
- data_ok outside WAIT/DRAIN is ignored; this is a bus protocol violation and must be asserted in the bench.

Decomposition:
- Op codes come from the shared defines.vh; no new op codes are added.
- Add shared constants there:
  - MEM state encodings (IDLE=0, REQ=1, WAIT=2, DONE=3, DRAIN=4).
  - SIZE_B/H/W.
- One combinational sub-module, mem_lane_align, holds all lane and alignment logic:
  - store replication;
  - load extraction and extension;
  - alignment error detection.
- The FSM stays in mem_access_ctrl.

Test Plan:
- LW addr 0x1000, addr_ok in cycle 0, data_ok in cycle 1 with 0xDEADBEEF -> rdata_o=0xDEADBEEF, done_o in cycle 2, stall_o=1 for exactly 2 cycles.
- LB addr 0x1003, rdata=0x80FF_0000 -> rdata_o=0xFFFFFF80; LBU at the same address -> 0x00000080; LH addr 0x1002 -> 0xFFFF80FF.
- SH addr 0x2002, wdata 0x1234ABCD -> data_wdata=0xABCDABCD, data_size=1, data_wr=1; done_o pulses after data_ok.
- LW addr 0x1001 -> adel_o=1, badvaddr_o=0x1001, data_req=0, stall_o=0; SH addr 0x2001 -> ades_o=1.
- addr_ok withheld 3 cycles -> data_req and data_addr stable; flush_i in REQ -> IDLE with no transaction; flush_i in WAIT -> DRAIN, then data_ok 0x55 -> done_o stays 0.
- hold_i=1 in DONE for 4 cycles -> rdata_o stable, no second data_req; assert rst mid-WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg: shared op codes, memory FSM states and bus size codes
package mem_access_ctrl_pkg;
   localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
   localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
   localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
   localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
   localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
   localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
   localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
   localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;
   typedef enum logic [2:0] {
      MEM_IDLE  = 3'd0,
      MEM_REQ   = 3'd1,
      MEM_WAIT  = 3'd2,
      MEM_DONE  = 3'd3,
      MEM_DRAIN = 3'd4
   } mem_state_e;
   function automatic logic [1:0] op_size(input logic [7:0] op);
      return (op == EXE_LW_OP || op == EXE_SW_OP) ? SIZE_W :
             (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) ? SIZE_H : SIZE_B;
   endfunction
endpackage

// File: rtl/mem_access_ctrl_lane_align.sv
// mem_lane_align: op decode, alignment check, store lane replication and load extraction
module mem_lane_align
   import mem_access_ctrl_pkg::*;
(
   input  logic [7:0]  op_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] wdata_i,
   input  logic [7:0]  ld_op_i,
   input  logic [1:0]  ld_off_i,
   input  logic [31:0] ld_raw_i,
   output logic        is_mem_o,
   output logic        is_store_o,
   output logic [1:0]  size_o,
   output logic        misalign_o,
   output logic [31:0] wdata_o,
   output logic [31:0] ld_data_o
);
   logic [7:0]  ld_b;
   logic [15:0] ld_h;
   assign is_store_o = op_i == EXE_SB_OP || op_i == EXE_SH_OP || op_i == EXE_SW_OP;
   assign is_mem_o   = is_store_o || op_i == EXE_LB_OP || op_i == EXE_LBU_OP ||
                       op_i == EXE_LH_OP || op_i == EXE_LHU_OP || op_i == EXE_LW_OP;
   assign size_o     = op_size(op_i);
   assign misalign_o = is_mem_o && ((size_o == SIZE_W && addr_lo_i != 2'b00) ||
                                    (size_o == SIZE_H && addr_lo_i[0]));
   assign wdata_o    = size_o == SIZE_B ? {4{wdata_i[7:0]}} :
                       size_o == SIZE_H ? {2{wdata_i[15:0]}} : wdata_i;
   assign ld_b       = ld_raw_i[{ld_off_i, 3'b000} +: 8];
   assign ld_h       = ld_raw_i[{ld_off_i[1], 4'b0000} +: 16];
   assign ld_data_o  = ld_op_i == EXE_LB_OP  ? {{24{ld_b[7]}}, ld_b} :
                       ld_op_i == EXE_LBU_OP ? {24'b0, ld_b} :
                       ld_op_i == EXE_LH_OP  ? {{16{ld_h[15]}}, ld_h} :
                       ld_op_i == EXE_LHU_OP ? {16'b0, ld_h} :
                       ld_op_i == EXE_LW_OP  ? ld_raw_i : 32'b0;
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-stage FSM driving a split address/data bus handshake
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_i,
   input  logic [7:0]        op_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              flush_i,
   input  logic              hold_i,
   output logic              stall_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              done_o,
   output logic              adel_o,
   output logic              ades_o,
   output logic [ADDR_W-1:0] badvaddr_o,
   output logic              data_req,
   output logic              data_wr,
   output logic [1:0]        data_size,
   output logic [ADDR_W-1:0] data_addr,
   output logic [DATA_W-1:0] data_wdata,
   input  logic              data_addr_ok,
   input  logic              data_data_ok,
   input  logic [DATA_W-1:0] data_rdata
);
   mem_state_e        state_q, state_d;
   logic [7:0]        op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        size_q, size_d;
   logic              wr_q, wr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
   logic              is_mem, is_store, misalign, mem_op, err, issue, req, stall, from_in;
   logic [1:0]        size;
   logic [DATA_W-1:0] wdata_rep, ld_data;

   mem_lane_align u_lane (
      .op_i       (op_i),
      .addr_lo_i  (addr_i[1:0]),
      .wdata_i    (wdata_i),
      .ld_op_i    (op_q),
      .ld_off_i   (addr_q[1:0]),
      .ld_raw_i   (data_rdata),
      .is_mem_o   (is_mem),
      .is_store_o (is_store),
      .size_o     (size),
      .misalign_o (misalign),
      .wdata_o    (wdata_rep),
      .ld_data_o  (ld_data)
   );

   assign mem_op = valid_i & is_mem;
   assign err    = mem_op & misalign & (state_q == MEM_IDLE || state_q == MEM_DRAIN);
   assign issue  = mem_op & ~misalign & ~flush_i & (state_q == MEM_IDLE);

   // next state, bus request and latching of the accepted access
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      addr_d  = addr_q;
      size_d  = size_q;
      wr_d    = wr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      req     = 1'b0;
      stall   = 1'b0;
      case (state_q)
         MEM_IDLE: begin
            req   = issue;
            stall = issue;
            if (issue) begin
               op_d    = op_i;
               addr_d  = addr_i;
               size_d  = size;
               wr_d    = is_store;
               wdata_d = wdata_rep;
               state_d = data_addr_ok ? MEM_WAIT : MEM_REQ;
            end
         end
         MEM_REQ: begin
            req     = ~flush_i;
            stall   = 1'b1;
            state_d = flush_i ? MEM_IDLE : data_addr_ok ? MEM_WAIT : MEM_REQ;
         end
         MEM_WAIT: begin
            stall   = 1'b1;
            rdata_d = (data_data_ok && !flush_i) ? ld_data : rdata_q;
            state_d = data_data_ok ? (flush_i ? MEM_IDLE : MEM_DONE) : flush_i ? MEM_DRAIN : MEM_WAIT;
         end
         MEM_DONE: state_d = (flush_i || !hold_i) ? MEM_IDLE : MEM_DONE;
         MEM_DRAIN: begin
            stall   = mem_op & ~misalign;
            state_d = data_data_ok ? MEM_IDLE : MEM_DRAIN;
         end
         default: state_d = MEM_IDLE;
      endcase
   end

   // state register and latched access fields
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= MEM_IDLE;
         op_q    <= '0;
         addr_q  <= '0;
         size_q  <= '0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         wr_q    <= wr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // in IDLE the bus is fed straight from the inputs; later the latched copy holds it stable
   assign from_in    = state_q == MEM_IDLE;
   assign stall_o    = rst & stall;
   assign data_req   = rst & req;
   assign data_wr    = data_req & (from_in ? is_store : wr_q);
   assign data_size  = data_req ? (from_in ? size : size_q) : SIZE_B;
   assign data_addr  = data_req ? (from_in ? addr_i : addr_q) : '0;
   assign data_wdata = data_req ? (from_in ? wdata_rep : wdata_q) : '0;
   assign done_o     = rst & (state_q == MEM_DONE);
   assign rdata_o    = done_o ? rdata_q : '0;
   assign adel_o     = rst & err & ~is_store;
   assign ades_o     = rst & err & is_store;
   assign badvaddr_o = (rst & err) ? addr_i : '0;
endmodule
